// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall plus multi-cycle squash after jumps and taken branches.
// Optional HAZ_STATS_EN adds saturating StallCount/FlushCount statistics ports.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ID_Instr,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        Busy
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} stateT;

  stateT         state, nextState;
  logic [CW-1:0] cnt, nextCnt;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic       jump, usesRt, loadUse;
  logic       unusedImm;

  assign op        = ID_Instr[31:26];
  assign rs        = ID_Instr[25:21];
  assign rt        = ID_Instr[20:16];
  assign fn        = ID_Instr[5:0];
  assign unusedImm = ^ID_Instr[15:6];

  assign jump    = (op == 6'b000010) || (op == 6'b000011) ||
                   ((op == 6'b000000) && (fn == 6'b001000));
  assign usesRt  = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
                   (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011);
  assign loadUse = EX_MemRead && (EX_Rt != 5'd0) &&
                   ((EX_Rt == rs) || (usesRt && (EX_Rt == rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // A load-use stall outranks a jump, so jr waits for its operand before redirecting.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      RUN: begin
        if ((EX_BranchTaken || (!loadUse && jump)) && (FLUSH_CYCLES > 1)) begin
          nextState = FLUSH;
          nextCnt   = RELOAD;
        end
      end
      FLUSH: begin
        if (EX_BranchTaken) begin
          nextCnt = RELOAD;
        end else if (cnt == CW'(1)) begin
          nextState = RUN;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt - CW'(1);
        end
      end
      default: begin
        nextState = RUN;
        nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    Busy      = 1'b0;
    if (Reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (state == FLUSH) begin
      IFIDFlush = 1'b1;
      IDEXFlush = EX_BranchTaken;
      Busy      = 1'b1;
    end else if (EX_BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (loadUse) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else if (jump) begin
      IFIDFlush = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  logic stallNow;
  assign stallNow = (state == RUN) && !EX_BranchTaken && loadUse;

  // Counters saturate rather than wrap so long runs never report a misleadingly small value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stallNow && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (IFIDFlush && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`endif

endmodule
